// File: rtl/shift_mult_ctrl_if.sv
// Control/handshake bundle between the shift-and-add multiplier controller
// and the surrounding system plus datapath.
interface shift_mult_ctrl_if #(
   parameter int CNT_W = 5
);
   logic             start;
   logic             abort;
   logic             lsb_in;
   logic             ld_op;
   logic             acc_clr;
   logic             acc_ld;
   logic             shr_en;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] iter;

   // System/datapath side: issues requests, returns the multiplier LSB.
   modport master (
      output start, abort, lsb_in,
      input  ld_op, acc_clr, acc_ld, shr_en, busy, done, iter
   );

   // Controller side.
   modport slave (
      input  start, abort, lsb_in,
      output ld_op, acc_clr, acc_ld, shr_en, busy, done, iter
   );
endinterface

// File: rtl/shift_mult_ctrl.sv
// Sequencer for an iterative shift-and-add multiplier: one cycle per 0 bit,
// two cycles (add then shift) per 1 bit, with start/busy/done handshake.
module shift_mult_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   shift_mult_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_TEST,
      S_ADD,
      S_DONE
   } state_e;

   generate
      if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt_w
         $error("CNT_W too narrow to count WIDTH iterations");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [CNT_W-1:0] iter_q, iter_d;
   logic             last_iter;

   assign last_iter = (iter_q == CNT_W'(WIDTH - 1));

   // NOTE: every signal driven here gets a default first, so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      iter_d      = iter_q;
      bus.ld_op   = 1'b0;
      bus.acc_clr = 1'b0;
      bus.acc_ld  = 1'b0;
      bus.shr_en  = 1'b0;
      bus.done    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_LOAD;
         end
         S_LOAD: begin
            bus.ld_op   = 1'b1;
            bus.acc_clr = 1'b1;
            iter_d      = '0;
            state_d     = S_TEST;
         end
         S_TEST: begin
            if (bus.lsb_in) begin
               // Add this cycle, shift and count in ADD.
               bus.acc_ld = 1'b1;
               state_d    = S_ADD;
            end else begin
               bus.shr_en = 1'b1;
               iter_d     = iter_q + CNT_W'(1);
               state_d    = last_iter ? S_DONE : S_TEST;
            end
         end
         S_ADD: begin
            bus.shr_en = 1'b1;
            iter_d     = iter_q + CNT_W'(1);
            state_d    = last_iter ? S_DONE : S_TEST;
         end
         S_DONE: begin
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            iter_d  = '0;
         end
      endcase

      // Abort only changes where we go next; this cycle's strobes still decode normally.
      if (bus.abort && (state_q inside {S_LOAD, S_TEST, S_ADD})) begin
         state_d = S_IDLE;
         iter_d  = '0;
      end
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.iter = iter_q;

   // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
      end
   end

   a_no_add_and_shift: assert property (
      @(posedge clk) disable iff (!rst) !(bus.acc_ld && bus.shr_en));

   a_iter_bounded: assert property (
      @(posedge clk) disable iff (!rst) (iter_q <= CNT_W'(WIDTH)));

   a_ld_only_in_load: assert property (
      @(posedge clk) disable iff (!rst) (bus.ld_op -> (state_q == S_LOAD)));

endmodule
